hazard_mem_ctrl: RTL and testbench

Pipeline control unit for the 5-stage RV32I core. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and generates stall, flush and forwarding selects. It owns a data-memory wait FSM that freezes the pipeline while a MEM-stage access is outstanding, and a timeout that locks the core on a hung access. A saturating stall-cycle counter supports performance debug.

---
 rtl/hazard_mem_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_mem_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_mem_ctrl.sv
// hazard_mem_ctrl: pipeline stall/flush/forward control for the RV32I core.
// Includes a data-memory wait FSM with hang timeout and a stall-cycle counter.
module hazard_mem_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             ResultSrcE0,
   input  logic             PCSrcE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             MemErr,
   output logic [CNT_W-1:0] StallCycles
);

   localparam int TW = 16;
   localparam logic [TW-1:0] TIMEOUT = TW'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ERR  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [TW-1:0] wait_cnt;
   logic [TW-1:0] wait_cnt_nxt;
   logic          mem_stall;
   logic          frozen;
   logic          lw_stall;

   // Operand forwarding select: MEM result beats WB result, x0 never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (RegWriteM && RdM != 5'd0 && RdM == rs)
         return 2'b10;
      else if (RegWriteW && RdW != 5'd0 && RdW == rs)
         return 2'b01;
      else
         return 2'b00;
   endfunction

   // Memory wait FSM state and wait counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Next-state: a ready in the timeout cycle still counts as completion.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      unique case (state)
         S_IDLE: begin
            if (MemReqM && !MemReadyM) begin
               state_nxt    = S_WAIT;
               wait_cnt_nxt = TW'(1);
            end
         end
         S_WAIT: begin
            if (MemReadyM) begin
               state_nxt    = S_IDLE;
               wait_cnt_nxt = '0;
            end else if (wait_cnt == TIMEOUT) begin
               state_nxt = S_ERR;
            end else begin
               wait_cnt_nxt = wait_cnt + TW'(1);
            end
         end
         S_ERR: begin
            state_nxt = S_ERR;
         end
         default: begin
            state_nxt    = S_IDLE;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   // Stall/flush generation: a frozen pipeline overrides load-use and branches.
   always_comb begin
      mem_stall = (state != S_ERR) && MemReqM && !MemReadyM;
      frozen    = mem_stall || (state == S_ERR);
      lw_stall  = ResultSrcE0 && (RdE != 5'd0) &&
                  ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (frozen) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else begin
         StallF = lw_stall;
         StallD = lw_stall;
         FlushD = PCSrcE;
         FlushE = lw_stall || PCSrcE;
      end
   end

   // Forwarding selects for both EX operands.
   always_comb begin
      ForwardAE = fwd_sel(Rs1E);
      ForwardBE = fwd_sel(Rs2E);
   end

   assign MemErr = (state == S_ERR);

   // Saturating count of cycles in which the PC is held.
   always_ff @(posedge clk) begin
      if (reset)
         StallCycles <= '0;
      else if (StallF && (StallCycles != {CNT_W{1'b1}}))
         StallCycles <= StallCycles + CNT_W'(1);
   end

endmodule

// File: tb/tb_hazard_mem_ctrl.sv
// tb_hazard_mem_ctrl: directed self-checking bench for hazard_mem_ctrl.
// Small timeout and counter width make the boundary cases reachable.
module tb_hazard_mem_ctrl;

   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 4;

   logic             clk;
   logic             reset;
   logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic             ResultSrcE0, PCSrcE, RegWriteM, RegWriteW;
   logic             MemReqM, MemReadyM;
   logic             StallF, StallD, StallE, StallM;
   logic             FlushD, FlushE, FlushW;
   logic [1:0]       ForwardAE, ForwardBE;
   logic             MemErr;
   logic [CNT_W-1:0] StallCycles;
   logic [6:0]       ctl;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] CTL_NONE   = 7'b0000000;
   localparam logic [6:0] CTL_LU     = 7'b1100010;
   localparam logic [6:0] CTL_BR     = 7'b0000110;
   localparam logic [6:0] CTL_FROZEN = 7'b1111001;

   assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

   hazard_mem_ctrl #(
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .Rs1D(Rs1D),
      .Rs2D(Rs2D),
      .Rs1E(Rs1E),
      .Rs2E(Rs2E),
      .RdE(RdE),
      .RdM(RdM),
      .RdW(RdW),
      .ResultSrcE0(ResultSrcE0),
      .PCSrcE(PCSrcE),
      .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW),
      .MemReqM(MemReqM),
      .MemReadyM(MemReadyM),
      .StallF(StallF),
      .StallD(StallD),
      .StallE(StallE),
      .StallM(StallM),
      .FlushD(FlushD),
      .FlushE(FlushE),
      .FlushW(FlushW),
      .ForwardAE(ForwardAE),
      .ForwardBE(ForwardBE),
      .MemErr(MemErr),
      .StallCycles(StallCycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
      RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
      ResultSrcE0 = 1'b0; PCSrcE = 1'b0;
      RegWriteM = 1'b0; RegWriteW = 1'b0;
      MemReqM = 1'b0; MemReadyM = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (ctl !== CTL_NONE) begin
         errors++;
         $display("FAIL reset_ctl got %b exp %b", ctl, CTL_NONE);
      end
      checks++;
      if (MemErr !== 1'b0) begin
         errors++;
         $display("FAIL reset_memerr got %b exp 0", MemErr);
      end
      checks++;
      if (StallCycles !== 4'd0) begin
         errors++;
         $display("FAIL reset_cnt got %0d exp 0", StallCycles);
      end
      checks++;
      if ({ForwardAE, ForwardBE} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_fwd got %b exp 0000", {ForwardAE, ForwardBE});
      end
   endtask

   task automatic test_forward();
      @(negedge clk);
      RegWriteM = 1'b1; RdM = 5'd5;
      RegWriteW = 1'b1; RdW = 5'd5;
      Rs1E = 5'd5; Rs2E = 5'd5;
      #1;
      checks++;
      if (ForwardAE !== 2'b10) begin
         errors++;
         $display("FAIL fwd_a_mem got %b exp 10", ForwardAE);
      end
      checks++;
      if (ForwardBE !== 2'b10) begin
         errors++;
         $display("FAIL fwd_b_mem got %b exp 10", ForwardBE);
      end
      RegWriteM = 1'b0;
      #1;
      checks++;
      if (ForwardAE !== 2'b01) begin
         errors++;
         $display("FAIL fwd_a_wb got %b exp 01", ForwardAE);
      end
      RegWriteM = 1'b1; RdM = 5'd0; Rs1E = 5'd0;
      Rs2E = 5'd6; RdW = 5'd6;
      #1;
      checks++;
      if (ForwardAE !== 2'b00) begin
         errors++;
         $display("FAIL fwd_a_x0 got %b exp 00", ForwardAE);
      end
      checks++;
      if (ForwardBE !== 2'b01) begin
         errors++;
         $display("FAIL fwd_b_wb got %b exp 01", ForwardBE);
      end
      idle_inputs();
   endtask

   task automatic test_load_use();
      @(negedge clk);
      ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
      #1;
      checks++;
      if (ctl !== CTL_LU) begin
         errors++;
         $display("FAIL lu_ctl got %b exp %b", ctl, CTL_LU);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (StallCycles !== 4'd1) begin
         errors++;
         $display("FAIL lu_cnt got %0d exp 1", StallCycles);
      end
      checks++;
      if (ctl !== CTL_NONE) begin
         errors++;
         $display("FAIL lu_release got %b exp %b", ctl, CTL_NONE);
      end
      ResultSrcE0 = 1'b1; RdE = 5'd0; Rs2D = 5'd0;
      #1;
      checks++;
      if (ctl !== CTL_NONE) begin
         errors++;
         $display("FAIL lu_x0 got %b exp %b", ctl, CTL_NONE);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (StallCycles !== 4'd1) begin
         errors++;
         $display("FAIL lu_x0_cnt got %0d exp 1", StallCycles);
      end
   endtask

   task automatic test_branch();
      @(negedge clk);
      ResultSrcE0 = 1'b1; RdE = 5'd3; Rs1D = 5'd3; PCSrcE = 1'b1;
      #1;
      checks++;
      if (ctl !== CTL_BR) begin
         errors++;
         $display("FAIL br_lu_ctl got %b exp %b", ctl, CTL_BR);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (StallCycles !== 4'd1) begin
         errors++;
         $display("FAIL br_cnt got %0d exp 1", StallCycles);
      end
   endtask

   task automatic test_mem_wait();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
         #1;
         checks++;
         if (ctl !== CTL_FROZEN) begin
            errors++;
            $display("FAIL wait_ctl[%0d] got %b exp %b", i, ctl, CTL_FROZEN);
         end
      end
      @(negedge clk);
      MemReadyM = 1'b1;
      #1;
      checks++;
      if (ctl !== CTL_BR) begin
         errors++;
         $display("FAIL wait_done_ctl got %b exp %b", ctl, CTL_BR);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (ctl !== CTL_NONE || MemErr !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle got %b/%b exp %b/0", ctl, MemErr, CTL_NONE);
      end
      checks++;
      if (StallCycles !== 4'd4) begin
         errors++;
         $display("FAIL wait_cnt got %0d exp 4", StallCycles);
      end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         MemReqM = 1'b1; MemReadyM = 1'b0;
         #1;
         checks++;
         if (ctl !== CTL_FROZEN || MemErr !== 1'b0) begin
            errors++;
            $display("FAIL to_wait[%0d] got %b/%b exp %b/0",
                     i, ctl, MemErr, CTL_FROZEN);
         end
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         MemReqM = 1'b0; PCSrcE = 1'b1;
         #1;
         checks++;
         if (ctl !== CTL_FROZEN || MemErr !== 1'b1) begin
            errors++;
            $display("FAIL to_err[%0d] got %b/%b exp %b/1",
                     i, ctl, MemErr, CTL_FROZEN);
         end
      end
      checks++;
      if (StallCycles !== 4'd10) begin
         errors++;
         $display("FAIL to_cnt got %0d exp 10", StallCycles);
      end
      do_reset();
      #1;
      checks++;
      if (ctl !== CTL_NONE || MemErr !== 1'b0) begin
         errors++;
         $display("FAIL to_reset got %b/%b exp %b/0", ctl, MemErr, CTL_NONE);
      end
      checks++;
      if (StallCycles !== 4'd0) begin
         errors++;
         $display("FAIL to_reset_cnt got %0d exp 0", StallCycles);
      end
   endtask

   task automatic test_boundary();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         MemReqM = 1'b1; MemReadyM = 1'b0;
      end
      @(negedge clk);
      MemReadyM = 1'b1;
      #1;
      checks++;
      if (ctl !== CTL_NONE) begin
         errors++;
         $display("FAIL bnd_ready_ctl got %b exp %b", ctl, CTL_NONE);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         idle_inputs();
         #1;
         checks++;
         if (MemErr !== 1'b0 || ctl !== CTL_NONE) begin
            errors++;
            $display("FAIL bnd_idle[%0d] got %b/%b exp 0/%b",
                     i, MemErr, ctl, CTL_NONE);
         end
      end
      checks++;
      if (StallCycles !== 4'd4) begin
         errors++;
         $display("FAIL bnd_cnt got %0d exp 4", StallCycles);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      ResultSrcE0 = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
      for (int i = 0; i < 14; i++) @(negedge clk);
      #1;
      checks++;
      if (StallCycles !== 4'd14) begin
         errors++;
         $display("FAIL sat_14 got %0d exp 14", StallCycles);
      end
      @(negedge clk);
      #1;
      checks++;
      if (StallCycles !== 4'd15) begin
         errors++;
         $display("FAIL sat_15 got %0d exp 15", StallCycles);
      end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (StallCycles !== 4'd15) begin
         errors++;
         $display("FAIL sat_hold got %0d exp 15", StallCycles);
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_forward();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_boundary();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
